// File: rtl/if_fetch_axi_pkg.sv
// if_fetch_axi_pkg: shared encodings and constants for the instruction-fetch stage
package if_fetch_axi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [2:0] ARPROT_INST = 3'b100;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic STOP = 1'b1;
  localparam logic NOT_STOP = 1'b0;
  localparam logic [31:0] ZEROWORD = 32'h0;
endpackage

// File: rtl/if_fetch_axi_pc_next.sv
// if_fetch_axi_pc_next: next-PC select, flush over branch over sequential advance
module if_fetch_axi_pc_next #(
  parameter int W = 32
) (
  input  logic         flush,
  input  logic [W-1:0] new_pc,
  input  logic         adv,
  input  logic         branch_flag,
  input  logic [W-1:0] branch_target,
  input  logic [W-1:0] pc,
  output logic [W-1:0] npc
);
  always_comb npc = flush ? new_pc : !adv ? pc : branch_flag ? branch_target : pc + W'(4);
endmodule

// File: rtl/if_fetch_axi.sv
// if_fetch_axi: IF stage owning the PC, one AXI-Lite read per pipeline advance.
// Define IFETCH_RRESP_CHK_EN to add if_fetch_err and zero the instruction on error responses.
module if_fetch_axi
  import if_fetch_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(if_fetch_axi_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_if,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
`ifdef IFETCH_RRESP_CHK_EN
  ,
  output logic              if_fetch_err
`endif
);
  state_t state;
  logic [ADDR_W-1:0] pc, npc;
  logic discard, beat_err, unused;
  assign arprot = ARPROT_INST;
`ifdef IFETCH_RRESP_CHK_EN
  assign beat_err = rresp != RESP_OKAY;
  assign unused = ^stall[5:1];
`else
  assign beat_err = 1'b0;
  assign unused = ^{rresp, stall[5:1]};
`endif
  if_fetch_axi_pc_next #(.W(ADDR_W)) u_pc_next (
    .flush(flush),
    .new_pc(new_pc),
    .adv(state == DONE && stall[0] == NOT_STOP),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .pc(pc),
    .npc(npc)
  );
  // A flushed fetch keeps its AR/R handshakes; discard marks the beat to drop
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      discard <= 1'b0;
      araddr <= '0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      if_pc <= '0;
      if_inst <= '0;
      stallreq_if <= 1'b0;
    end else begin
      pc <= npc;
      case (state)
        IDLE: begin
          stallreq_if <= 1'b1;
          if (flush || stallreq_if) begin
            state <= ADDR;
            araddr <= npc;
            arvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (flush) discard <= 1'b1;
          if (arready) begin
            state <= DATA;
            arvalid <= 1'b0;
            rready <= 1'b1;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (flush || discard) begin
              discard <= 1'b0;
              state <= ADDR;
              araddr <= npc;
              arvalid <= 1'b1;
            end else begin
              state <= DONE;
              if_pc <= pc;
              if_inst <= beat_err ? DATA_W'(ZEROWORD) : rdata;
              stallreq_if <= 1'b0;
            end
          end else if (flush) discard <= 1'b1;
        end
        DONE: begin
          if (flush || stall[0] == NOT_STOP) begin
            state <= ADDR;
            araddr <= npc;
            arvalid <= 1'b1;
            if_inst <= DATA_W'(ZEROWORD);
            stallreq_if <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef IFETCH_RRESP_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst) if_fetch_err <= 1'b0;
    else if (state == DATA && rvalid && !flush && !discard) if_fetch_err <= beat_err;
    else if (state == DONE && (flush || stall[0] == NOT_STOP)) if_fetch_err <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_if_fetch_axi.sv
// tb_if_fetch_axi: directed bench for if_fetch_axi with an AXI-Lite slave and a transaction-level model
module tb_if_fetch_axi;
  logic clk = 1'b0;
  logic rst, flush, branch_flag, stallreq_if, arvalid, arready, rvalid, rready, resp_bad;
  logic [5:0] stall;
  logic [31:0] new_pc, branch_target, if_pc, if_inst, araddr, rdata;
  logic [2:0] arprot;
  logic [1:0] rresp, resp_cfg;
  int n_chk = 0, n_fail = 0, ar_delay, r_delay;
`ifdef IFETCH_RRESP_CHK_EN
  logic if_fetch_err, m_err;
  assign resp_bad = rresp != 2'b00;
`else
  assign resp_bad = 1'b0;
`endif
  always #5 clk = ~clk;

  if_fetch_axi dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef IFETCH_RRESP_CHK_EN
    , .if_fetch_err(if_fetch_err)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'hBFC00000 ? 32'h24010001 : a == 32'hBFC00104 ? 32'hDEADBEEF : {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave: arready after ar_delay cycles of arvalid, rvalid r_delay cycles after AR
  initial begin
    logic ar_t, r_t, rs, busy;
    logic [31:0] a_t, raddr;
    int ctr;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; busy = 0; ctr = 0; raddr = 0;
    forever begin
      @(posedge clk);
      ar_t = arvalid && arready; r_t = rvalid && rready; a_t = araddr; rs = rst;
      #1;
      if (!rs) begin
        arready = 0; rvalid = 0; busy = 0; ctr = 0;
      end else begin
        if (ar_t) begin arready = 0; busy = 1; raddr = a_t; ctr = 0; end
        if (r_t) begin rvalid = 0; busy = 0; ctr = 0; end
        if (!busy && arvalid && !arready) begin
          if (ctr >= ar_delay) arready = 1; else ctr++;
        end else if (busy && !rvalid) begin
          if (ctr >= r_delay) begin rvalid = 1; rdata = mem(raddr); rresp = resp_cfg; end else ctr++;
        end
      end
    end
  end

  // Model: which address must be fetched next and which instruction IF is holding
  int m_boot;
  logic m_hold, m_stale;
  logic [31:0] m_next, m_fetch, m_pc, m_inst;
  always @(posedge clk) begin
    if (!rst) begin
      m_boot <= 0; m_hold <= 0; m_stale <= 0; m_next <= 32'hBFC00000;
    end else if (m_boot < 2) m_boot <= m_boot + 1;
    else begin
      if (arvalid && arready && !m_stale) m_fetch <= m_next;
      if (flush) begin
        m_stale <= !m_hold && !(rvalid && rready);
        m_next <= new_pc;
        m_hold <= 0;
      end else if (m_hold && !stall[0]) begin
        m_hold <= 0;
        m_next <= branch_flag ? branch_target : m_pc + 32'd4;
      end else if (rvalid && rready) begin
        if (m_stale) m_stale <= 0;
        else begin
          m_hold <= 1; m_pc <= m_fetch; m_inst <= resp_bad ? 32'h0 : mem(m_fetch);
`ifdef IFETCH_RRESP_CHK_EN
          m_err <= resp_bad;
`endif
        end
      end
    end
  end

  logic p_pend;
  logic [31:0] p_addr;
  always @(negedge clk) begin
    if (!rst) p_pend <= 0;
    else begin
      chk("arprot", 32'(arprot), 32'h4);
      chk("stallreq_if", 32'(stallreq_if), 32'(m_boot >= 1 && !m_hold));
      chk("if_inst", if_inst, m_hold ? m_inst : 32'h0);
      if (m_hold) chk("if_pc", if_pc, m_pc);
      if (p_pend) begin
        chk("ar_hold_valid", 32'(arvalid), 32'h1);
        chk("ar_hold_addr", araddr, p_addr);
      end
      if (arvalid && arready && !m_stale) chk("araddr", araddr, m_next);
`ifdef IFETCH_RRESP_CHK_EN
      chk("if_fetch_err", 32'(if_fetch_err), 32'(m_hold && m_err));
`endif
      p_pend <= arvalid && !arready;
      p_addr <= araddr;
    end
  end

  function automatic logic cond(input int k);
    return k == 0 ? !stallreq_if : k == 1 ? arvalid && arready : k == 2 ? rready : rvalid && rready;
  endfunction

  task automatic wait_for(input int k, input string name);
    int n = 0;
    while (!cond(k) && n < 50) begin @(negedge clk); n++; end
    chk({"wait ", name}, 32'(cond(k)), 32'h1);
  endtask

  task automatic advance();
    #1 stall = 6'b000000;
    @(negedge clk);
    #1 stall = 6'b000001;
  endtask

  initial begin
    int cnt;
    rst = 0; stall = 6'b000001; flush = 0; new_pc = 0; branch_flag = 0; branch_target = 0;
    ar_delay = 0; r_delay = 0; resp_cfg = 0;
    repeat (3) @(negedge clk);
    chk("rst arvalid", 32'(arvalid), 32'h0);
    chk("rst rready", 32'(rready), 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst if_inst", if_inst, 32'h0);
    chk("rst stallreq", 32'(stallreq_if), 32'h0);
    #1 rst = 1;
    @(negedge clk);
    chk("idle arvalid", 32'(arvalid), 32'h0);
    chk("idle stallreq", 32'(stallreq_if), 32'h1);
    @(negedge clk);
    chk("first arvalid", 32'(arvalid), 32'h1);
    chk("first araddr", araddr, 32'hBFC00000);
    repeat (2) @(negedge clk);
    chk("first stallreq", 32'(stallreq_if), 32'h0);
    chk("first if_pc", if_pc, 32'hBFC00000);
    chk("first if_inst", if_inst, 32'h24010001);
    #1 branch_flag = 1; branch_target = 32'hBFC00100;
    repeat (2) begin
      @(negedge clk);
      chk("hold if_inst", if_inst, 32'h24010001);
      chk("hold arvalid", 32'(arvalid), 32'h0);
    end
    #1 ar_delay = 5; stall = 6'b000000;
    @(negedge clk);
    chk("branch arvalid", 32'(arvalid), 32'h1);
    chk("branch araddr", araddr, 32'hBFC00100);
    #1 stall = 6'b000001; branch_flag = 0;
    cnt = 0;
    while (arvalid && !arready && cnt < 20) begin cnt++; @(negedge clk); end
    chk("ar_wait cycles", cnt, 5);
    #1 ar_delay = 0; r_delay = 3;
    wait_for(0, "done slow");
    chk("slow if_pc", if_pc, 32'hBFC00100);
    chk("slow if_inst", if_inst, 32'h0100BFC0);
    advance();
    wait_for(2, "data");
    #1 flush = 1; new_pc = 32'hBFC00380;
    @(negedge clk);
    #1 flush = 0;
    chk("flushed if_inst", if_inst, 32'h0);
    wait_for(1, "ar after flush");
    chk("flush araddr", araddr, 32'hBFC00380);
    wait_for(0, "done flush");
    chk("flush if_pc", if_pc, 32'hBFC00380);
    chk("flush if_inst", if_inst, 32'h0380BFC0);
    #1 r_delay = 0;
    advance();
    wait_for(3, "r beat");
    #1 flush = 1; new_pc = 32'hFFFFFFFC;
    @(negedge clk);
    #1 flush = 0;
    wait_for(1, "ar after beat flush");
    chk("beat flush araddr", araddr, 32'hFFFFFFFC);
    wait_for(0, "done top");
    chk("top if_pc", if_pc, 32'hFFFFFFFC);
    chk("top if_inst", if_inst, 32'hFFFCFFFF);
    advance();
    wait_for(1, "ar wrap");
    chk("wrap araddr", araddr, 32'h00000000);
    wait_for(0, "done wrap");
    chk("wrap if_pc", if_pc, 32'h0);
    #1 flush = 1; new_pc = 32'hBFC00000; branch_flag = 1; branch_target = 32'h12345678;
    @(negedge clk);
    #1 flush = 0; branch_flag = 0;
    wait_for(1, "ar done flush");
    chk("done flush araddr", araddr, 32'hBFC00000);
    wait_for(0, "done refetch");
    chk("refetch if_inst", if_inst, 32'h24010001);
`ifdef IFETCH_RRESP_CHK_EN
    #1 resp_cfg = 2'b10;
    advance();
    wait_for(0, "done err");
    chk("err if_inst", if_inst, 32'h0);
    chk("err flag", 32'(if_fetch_err), 32'h1);
    #1 resp_cfg = 2'b00;
    advance();
    chk("err cleared", 32'(if_fetch_err), 32'h0);
`endif
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
